// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter: round-robin sharing of one fixed-latency pipeline
// among NREQ requesters, with result steering, a quiesce FSM and an error flag.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid / req_data / req_ready : requester issue side (one-hot grant)
//   pipe_input_valid / pipe_x        : to the shared pipeline
//   pipe_output_valid / pipe_out     : from the shared pipeline
//   res_valid / res_data             : result strobe to the owner, shared data
//   quiesce / idle                   : drain request and halted status
//   err                              : sticky tag/valid mismatch
//   issue_cnt                        : per-requester 16-bit issue counters,
//                                      only when PIPE_ARB_STATS_EN is defined
module pipe_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              pipe_input_valid,
  output logic [W-1:0]      pipe_x,
  input  logic              pipe_output_valid,
  input  logic [W-1:0]      pipe_out,
  output logic [NREQ-1:0]   res_valid,
  output logic [W-1:0]      res_data,
  input  logic              quiesce,
  output logic              idle,
  output logic              err
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] issue_cnt
`endif
);

  localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [TAG_W-1:0]                rr_q, rr_d;
  logic [CNT_W-1:0]                inflight_q, inflight_d;
  logic [LATENCY-1:0]              vld_q, vld_d;
  logic [LATENCY-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic                            err_q, err_d;

  logic                            found;
  logic [TAG_W-1:0]                gnt_idx;
  logic                            issue;
  logic                            ov;
  logic [TAG_W-1:0]                tail_tag;
  logic                            tail_vld;
  logic                            over, under;

  // First valid requester at or after rr_q, wrapping mod NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = TAG_W'(j);
      end
    end
  end

  // Outputs are forced low while reset is held.
  assign issue = rst && found && (state_q == RUN) && !quiesce;
  assign ov    = rst && pipe_output_valid;

  assign tail_tag = tag_q[LATENCY-1];
  assign tail_vld = vld_q[LATENCY-1];

  always_comb begin
    req_ready = '0;
    pipe_x    = '0;
    if (issue) begin
      req_ready[gnt_idx] = 1'b1;
      pipe_x             = req_data[gnt_idx*W +: W];
    end
  end

  assign pipe_input_valid = issue;

  always_comb begin
    res_valid = '0;
    res_data  = '0;
    if (ov) begin
      res_valid[tail_tag] = 1'b1;
      res_data            = pipe_out;
    end
  end

  assign idle = (state_q == HALT);
  assign err  = err_q;

  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = issue;
    tag_d[0] = gnt_idx;
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
  end

  // Saturating occupancy; hitting either rail marks an error.
  always_comb begin
    inflight_d = inflight_q;
    over       = 1'b0;
    under      = 1'b0;
    if (issue && !ov) begin
      if (inflight_q == CNT_W'(LATENCY)) over = 1'b1;
      else inflight_d = inflight_q + CNT_W'(1);
    end else if (ov && !issue) begin
      if (inflight_q == '0) under = 1'b1;
      else inflight_d = inflight_q - CNT_W'(1);
    end
  end

  assign err_d = err_q | (ov != tail_vld) | over | under;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (quiesce) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce) state_d = RUN;
        else if (inflight_q == '0) state_d = HALT;
      end
      HALT:    if (!quiesce) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      rr_q       <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
    end
  end

`ifdef PIPE_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && cnt_q[gnt_idx] != 16'hFFFF) begin
      cnt_d[gnt_idx] = cnt_q[gnt_idx] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// tb_pipe_share_arbiter: directed bench for pipe_share_arbiter with a
// 2-stage x+1 pipeline model; run with or without PIPE_ARB_STATS_EN.
module tb_pipe_share_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         pipe_input_valid;
  logic [31:0]  pipe_x;
  logic         pipe_output_valid;
  logic [31:0]  pipe_out;
  logic [3:0]   res_valid;
  logic [31:0]  res_data;
  logic         quiesce;
  logic         idle;
  logic         err;
`ifdef PIPE_ARB_STATS_EN
  logic [63:0]  issue_cnt;
`endif

  int n_run;
  int n_fail;

  logic         force_ov;
  logic [1:0]   p_v;
  logic [31:0]  p_d0, p_d1;

  pipe_share_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_x            (pipe_x),
    .pipe_output_valid (pipe_output_valid),
    .pipe_out          (pipe_out),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .quiesce           (quiesce),
    .idle              (idle),
    .err               (err)
`ifdef PIPE_ARB_STATS_EN
    ,
    .issue_cnt         (issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage pipeline computing x+1, cleared by the same reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_v  <= '0;
      p_d0 <= '0;
      p_d1 <= '0;
    end else begin
      p_v  <= {p_v[0], pipe_input_valid};
      p_d0 <= pipe_x + 32'd1;
      p_d1 <= p_d0;
    end
  end

  assign pipe_output_valid = force_ov | p_v[1];
  assign pipe_out          = p_d1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_rdy;
  logic [3:0]  exp_res;
  logic [31:0] exp_dat;
  logic [3:0]  sp_tab [4];

  initial begin
    n_run     = 0;
    n_fail    = 0;
    force_ov  = 1'b0;
    quiesce   = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h10 + i;
    rst = 1'b0;

    // Reset holds outputs low.
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_piv", 32'(pipe_input_valid), 32'h0);
    check("rst_idle", 32'(idle), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    next();
    rst = 1'b1;

    // Round robin over all four, results two cycles later.
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      check("rr_ready", 32'(req_ready), 32'(exp_rdy));
      if (k < 8) check("rr_x", pipe_x, 32'h10 + 32'(k % 4));
      exp_res = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
      exp_dat = (k >= 2) ? 32'h11 + 32'((k - 2) % 4) : 32'h0;
      check("rr_res", 32'(res_valid), 32'(exp_res));
      check("rr_dat", res_data, exp_dat);
      next();
    end
    check("rr_err", 32'(err), 32'h0);

    // Sparse requesters 1 and 3.
    sp_tab[0] = 4'b0010;
    sp_tab[1] = 4'b1000;
    sp_tab[2] = 4'b0010;
    sp_tab[3] = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      exp_rdy = (k < 4) ? sp_tab[k] : 4'b0000;
      check("sp_ready", 32'(req_ready), 32'(exp_rdy));
      exp_res = (k >= 2) ? sp_tab[k-2] : 4'b0000;
      check("sp_res", 32'(res_valid), 32'(exp_res));
      check("sp_res02", 32'(res_valid & 4'b0101), 32'h0);
      next();
    end

    // Drain with two ops in flight.
    req_valid = 4'b0011;
    @(negedge clk);
    check("dr_a", 32'(req_ready), 32'h1);
    next();
    @(negedge clk);
    check("dr_b", 32'(req_ready), 32'h2);
    next();
    quiesce   = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("dr_c_rdy", 32'(req_ready), 32'h0);
    check("dr_c_piv", 32'(pipe_input_valid), 32'h0);
    check("dr_c_res", 32'(res_valid), 32'h1);
    check("dr_c_dat", res_data, 32'h11);
    next();
    @(negedge clk);
    check("dr_d_rdy", 32'(req_ready), 32'h0);
    check("dr_d_res", 32'(res_valid), 32'h2);
    check("dr_d_dat", res_data, 32'h12);
    check("dr_d_idle", 32'(idle), 32'h0);
    next();
    @(negedge clk);
    check("dr_e_idle", 32'(idle), 32'h0);
    check("dr_e_res", 32'(res_valid), 32'h0);
    next();
    @(negedge clk);
    check("dr_f_idle", 32'(idle), 32'h1);
    check("dr_f_rdy", 32'(req_ready), 32'h0);
    next();
    quiesce = 1'b0;
    @(negedge clk);
    check("dr_g_idle", 32'(idle), 32'h1);
    check("dr_g_rdy", 32'(req_ready), 32'h0);
    next();
    @(negedge clk);
    check("dr_h_idle", 32'(idle), 32'h0);
    check("dr_h_rdy", 32'(req_ready), 32'h4);
    next();
    req_valid = 4'b0000;
    @(negedge clk);
    next();
    @(negedge clk);
    check("dr_res", 32'(res_valid), 32'h4);
    check("dr_dat", res_data, 32'h13);
    check("dr_err", 32'(err), 32'h0);
    next();

    // Async reset with two ops in flight (grants 3 then 0).
    req_valid = 4'b1111;
    @(negedge clk);
    check("ar_g0", 32'(req_ready), 32'h8);
    next();
    @(negedge clk);
    check("ar_g1", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    #1;
    rst = 1'b0;
    #1;
    check("ar_in_ready", 32'(req_ready), 32'h0);
    check("ar_in_res", 32'(res_valid), 32'h0);
    check("ar_in_idle", 32'(idle), 32'h0);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ar_res", 32'(res_valid), 32'h0);
      check("ar_inflight", 32'(dut.inflight_q), 32'h0);
      check("ar_err", 32'(err), 32'h0);
      next();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    check("ar_rr0", 32'(req_ready), 32'h1);
    next();
    req_valid = 4'b0000;
    next();
    next();
    next();

    // Spurious pipeline output sets a sticky error.
    force_ov = 1'b1;
    @(negedge clk);
    check("er_pre", 32'(err), 32'h0);
    next();
    force_ov = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("er_sticky", 32'(err), 32'h1);
      next();
    end
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("er_clr", 32'(err), 32'h0);
    next();

`ifdef PIPE_ARB_STATS_EN
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) next();
    req_valid = 4'b0000;
    @(negedge clk);
    check("st_cnt5", 32'(issue_cnt[47:32]), 32'd5);
    check("st_cnt0", 32'(issue_cnt[15:0]), 32'd0);
    next();
    req_valid = 4'b0100;
    for (int k = 0; k < 65535; k++) next();
    req_valid = 4'b0000;
    @(negedge clk);
    check("st_sat", 32'(issue_cnt[47:32]), 32'hFFFF);
    next();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
